// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop sync, per-button debounce FSMs,
// sticky press flags and a word-wide switch debouncer.
module io_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int SW_WIDTH        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                buttonL_raw,
   input  logic                buttonR_raw,
   input  logic [SW_WIDTH-1:0] switch_raw,
   input  logic                clearL,
   input  logic                clearR,
   output logic                buttonL,
   output logic                buttonR,
   output logic                pressL,
   output logic                pressR,
   output logic                riseL,
   output logic                riseR,
   output logic [SW_WIDTH-1:0] switch,
   output logic                switch_changed
);

   localparam int CLOG = $clog2(DEBOUNCE_CYCLES);
   localparam int CW   = (CLOG > 20) ? CLOG : 20;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ARM_PRESS,
      PRESSED,
      ARM_RELEASE
   } btn_state_t;

   logic [1:0]          btn_s1;
   logic [1:0]          btn_s2;
   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;
   logic [SW_WIDTH-1:0] cand;
   logic [CW-1:0]       scnt;
   logic [SW_WIDTH-1:0] sw_q;
   logic                sw_chg;

   btn_state_t [1:0]    state;
   logic [1:0][CW-1:0]  cnt;
   logic [1:0]          lvl;
   logic [1:0]          rise;
   logic [1:0]          press;
   logic [1:0]          clr;

   assign clr = {clearR, clearL};

   always_ff @(posedge clk) begin
      if (!rst) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         btn_s1 <= {buttonR_raw, buttonL_raw};
         btn_s2 <= btn_s1;
         sw_s1  <= switch_raw;
         sw_s2  <= sw_s1;
      end
   end

   // Index 0 is the left button, index 1 the right one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= {IDLE, IDLE};
         cnt   <= '0;
         lvl   <= '0;
         rise  <= '0;
         press <= '0;
      end else begin
         rise <= '0;
         for (int b = 0; b < 2; b++) begin
            if (clr[b])
               press[b] <= 1'b0;
            unique case (state[b])
               IDLE: begin
                  if (btn_s2[b]) begin
                     state[b] <= ARM_PRESS;
                     cnt[b]   <= '0;
                  end
               end
               ARM_PRESS: begin
                  if (!btn_s2[b]) begin
                     state[b] <= IDLE;
                     cnt[b]   <= '0;
                  end else if (cnt[b] == CNT_MAX) begin
                     // set after clear so a same-edge clear loses
                     state[b] <= PRESSED;
                     lvl[b]   <= 1'b1;
                     rise[b]  <= 1'b1;
                     press[b] <= 1'b1;
                  end else begin
                     cnt[b] <= cnt[b] + CW'(1);
                  end
               end
               PRESSED: begin
                  if (!btn_s2[b]) begin
                     state[b] <= ARM_RELEASE;
                     cnt[b]   <= '0;
                  end
               end
               ARM_RELEASE: begin
                  if (btn_s2[b]) begin
                     state[b] <= PRESSED;
                     cnt[b]   <= '0;
                  end else if (cnt[b] == CNT_MAX) begin
                     state[b] <= IDLE;
                     lvl[b]   <= 1'b0;
                  end else begin
                     cnt[b] <= cnt[b] + CW'(1);
                  end
               end
               default: begin
                  state[b] <= IDLE;
                  cnt[b]   <= '0;
               end
            endcase
         end
      end
   end

   // Any bit moving restarts the whole word's stability count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cand   <= '0;
         scnt   <= '0;
         sw_q   <= '0;
         sw_chg <= 1'b0;
      end else begin
         sw_chg <= 1'b0;
         if (sw_s2 != cand) begin
            cand <= sw_s2;
            scnt <= '0;
         end else if (scnt == CNT_MAX && cand != sw_q) begin
            sw_q   <= cand;
            sw_chg <= 1'b1;
         end else if (scnt != CNT_MAX) begin
            scnt <= scnt + CW'(1);
         end
      end
   end

   assign buttonL        = lvl[0];
   assign buttonR        = lvl[1];
   assign pressL         = press[0];
   assign pressR         = press[1];
   assign riseL          = rise[0];
   assign riseR          = rise[1];
   assign switch         = sw_q;
   assign switch_changed = sw_chg;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4:
// expected output events are queued at stimulus time and matched on output.
module tb_io_input_conditioner;

   localparam int D  = 4;
   localparam int SW = 16;
   localparam int LAT = D + 3;

   localparam int S_BL = 0;
   localparam int S_BR = 1;
   localparam int S_PL = 2;
   localparam int S_PR = 3;
   localparam int S_RL = 4;
   localparam int S_RR = 5;
   localparam int S_SW = 6;
   localparam int S_SC = 7;

   typedef struct {
      int          sid;
      int          cyc;
      logic [31:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          buttonL_raw;
   logic          buttonR_raw;
   logic [SW-1:0] switch_raw;
   logic          clearL;
   logic          clearR;
   logic          buttonL;
   logic          buttonR;
   logic          pressL;
   logic          pressR;
   logic          riseL;
   logic          riseR;
   logic [SW-1:0] switch;
   logic          switch_changed;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t sbq[$];

   logic          p_bl = 1'b0;
   logic          p_br = 1'b0;
   logic          p_pl = 1'b0;
   logic          p_pr = 1'b0;
   logic [SW-1:0] p_sw = '0;

   io_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .SW_WIDTH(SW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .buttonL_raw(buttonL_raw),
      .buttonR_raw(buttonR_raw),
      .switch_raw(switch_raw),
      .clearL(clearL),
      .clearR(clearR),
      .buttonL(buttonL),
      .buttonR(buttonR),
      .pressL(pressL),
      .pressR(pressR),
      .riseL(riseL),
      .riseR(riseR),
      .switch(switch),
      .switch_changed(switch_changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input int sid, input int c,
                           input logic [31:0] v);
      exp_t e;
      e.sid = sid;
      e.cyc = c;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic observe(input int sid, input string tag,
                          input logic [31:0] v);
      int idx;
      idx = -1;
      for (int i = 0; i < sbq.size(); i++) begin
         if (idx < 0 && sbq[i].sid == sid)
            idx = i;
      end
      if (idx < 0) begin
         check({tag, "_unexpected_at_cycle"}, cyc, 32'hFFFF_FFFF);
      end else begin
         check({tag, "_cycle"}, cyc, sbq[idx].cyc);
         check({tag, "_value"}, v, sbq[idx].val);
         sbq.delete(idx);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (buttonL !== p_bl) observe(S_BL, "buttonL", 32'(buttonL));
         if (buttonR !== p_br) observe(S_BR, "buttonR", 32'(buttonR));
         if (pressL !== p_pl)  observe(S_PL, "pressL", 32'(pressL));
         if (pressR !== p_pr)  observe(S_PR, "pressR", 32'(pressR));
         if (riseL !== 1'b0)   observe(S_RL, "riseL", 32'(riseL));
         if (riseR !== 1'b0)   observe(S_RR, "riseR", 32'(riseR));
         if (switch !== p_sw)  observe(S_SW, "switch", 32'(switch));
         if (switch_changed !== 1'b0)
            observe(S_SC, "switch_changed", 32'(switch_changed));
         p_bl <= buttonL;
         p_br <= buttonR;
         p_pl <= pressL;
         p_pr <= pressR;
         p_sw <= switch;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"},
            32'({buttonL, buttonR, pressL, pressR,
                 riseL, riseR, switch_changed}), 32'h0);
      check({tag, "_switch"}, 32'(switch), 32'h0);
   endtask

   initial begin
      rst         = 1'b0;
      buttonL_raw = 1'b0;
      buttonR_raw = 1'b0;
      switch_raw  = '0;
      clearL      = 1'b0;
      clearR      = 1'b0;
      tick(3);
      check_all_zero("reset_state");
      rst    = 1'b1;
      mon_en = 1'b1;
      while (cyc < 9) tick(1);

      // clean press on L, sampled first at edge 10
      buttonL_raw = 1'b1;
      push_exp(S_BL, cyc + LAT, 1);
      push_exp(S_RL, cyc + LAT, 1);
      push_exp(S_PL, cyc + LAT, 1);
      tick(12);

      // bounce on R: 3 high, 1 low, then held
      buttonR_raw = 1'b1;
      tick(3);
      buttonR_raw = 1'b0;
      tick(1);
      buttonR_raw = 1'b1;
      push_exp(S_BR, cyc + LAT, 1);
      push_exp(S_RR, cyc + LAT, 1);
      push_exp(S_PR, cyc + LAT, 1);
      tick(12);

      // release L: level falls, no rise, press stays
      buttonL_raw = 1'b0;
      push_exp(S_BL, cyc + LAT, 0);
      tick(12);

      // clear the sticky flag, then a clear on an already-clear flag
      clearL = 1'b1;
      push_exp(S_PL, cyc + 1, 0);
      tick(1);
      clearL = 1'b0;
      tick(3);
      clearL = 1'b1;
      tick(1);
      clearL = 1'b0;
      tick(3);
      check("clear_idle_pressL", 32'(pressL), 32'h0);

      // clear on the same edge that sets the flag
      buttonL_raw = 1'b1;
      push_exp(S_BL, cyc + LAT, 1);
      push_exp(S_RL, cyc + LAT, 1);
      push_exp(S_PL, cyc + LAT, 1);
      tick(LAT - 1);
      clearL = 1'b1;
      tick(1);
      clearL = 1'b0;
      check("collision_pressL", 32'(pressL), 32'h1);
      tick(6);

      // switch word with a 2-cycle glitch on bit 3 mid-count
      switch_raw = 16'hA5A5;
      tick(3);
      switch_raw = 16'hA5AD;
      tick(2);
      switch_raw = 16'hA5A5;
      push_exp(S_SW, cyc + LAT, 32'hA5A5);
      push_exp(S_SC, cyc + LAT, 1);
      tick(12);
      check("switch_settled", 32'(switch), 32'hA5A5);

      // release both buttons
      buttonL_raw = 1'b0;
      buttonR_raw = 1'b0;
      push_exp(S_BL, cyc + LAT, 0);
      push_exp(S_BR, cyc + LAT, 0);
      tick(12);

      // reset while L is in ARM_PRESS
      buttonL_raw = 1'b1;
      tick(4);
      rst = 1'b0;
      push_exp(S_PL, cyc + 1, 0);
      push_exp(S_PR, cyc + 1, 0);
      push_exp(S_SW, cyc + 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_all_zero("in_reset");
      end
      rst = 1'b1;
      push_exp(S_BL, cyc + LAT, 1);
      push_exp(S_RL, cyc + LAT, 1);
      push_exp(S_PL, cyc + LAT, 1);
      push_exp(S_SW, cyc + LAT, 32'hA5A5);
      push_exp(S_SC, cyc + LAT, 1);
      tick(14);
      check("after_reset_pressL", 32'(pressL), 32'h1);

      check("scoreboard_left", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
